// File: rtl/mem_access_ctrl_if.sv
// Requester, result and RAM-side handshake signals for mem_access_ctrl.
// master = controller side, slave = requesters plus RAM (testbench side).
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic              ds_req;
  logic              ds_we;
  logic [1:0]        ds_size;
  logic [ADDR_W-1:0] ds_addr;
  logic [DATA_W-1:0] ds_wdata;
  logic              ds_done;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              mem_mfa;
  logic              mem_rw;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_moc;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  if_req, if_addr, ds_req, ds_we, ds_size, ds_addr, ds_wdata, mem_moc, mem_rdata,
    output if_done, ds_done, rdata, err, mem_mfa, mem_rw, mem_size, mem_addr, mem_wdata
  );

  modport slave (
    output if_req, if_addr, ds_req, ds_we, ds_size, ds_addr, ds_wdata, mem_moc, mem_rdata,
    input  if_done, ds_done, rdata, err, mem_mfa, mem_rw, mem_size, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Round-robin sequencer sharing one RAM port between instruction fetch and load/store,
// driving the MFA/MOC handshake with timeout and alignment checking; all outputs registered.
module mem_access_ctrl #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              Clk,
  input  logic              Clear,
  mem_access_ctrl_if.master bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_COMPLETE} state_t;

  state_t            state_q;
  logic              last_ds_q;
  logic              gnt_ds_q;
  logic              bad_q;
  logic              mfa_q;
  logic              rw_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [DATA_W-1:0] res_q;
  logic              res_err_q;
  logic              if_done_q;
  logic              ds_done_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              pick_ds;
  logic              ds_bad;
  logic              if_bad;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
    return (size == 2'b11) || (size == 2'b01 && lsb[0]) || (size == 2'b10 && lsb != 2'b00);
  endfunction

  // DS wins only when IF is idle or IF was the last one served.
  assign pick_ds = bus.ds_req & (~bus.if_req | ~last_ds_q);
  assign ds_bad  = misaligned(bus.ds_size, bus.ds_addr[1:0]);
  assign if_bad  = misaligned(2'b10, bus.if_addr[1:0]);
  assign cnt_d   = cnt_q + CNT_W'(1);

  always_ff @(posedge Clk or negedge Clear) begin
    if (!Clear) begin
      state_q   <= S_IDLE;
      last_ds_q <= 1'b1;
      gnt_ds_q  <= 1'b0;
      bad_q     <= 1'b0;
      mfa_q     <= 1'b0;
      rw_q      <= 1'b0;
      size_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      res_err_q <= 1'b0;
      if_done_q <= 1'b0;
      ds_done_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // The done cycle is spent here without granting, giving requesters time to drop req.
          if (if_done_q || ds_done_q) begin
            if_done_q <= 1'b0;
            ds_done_q <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
          end else if (bus.if_req || bus.ds_req) begin
            gnt_ds_q  <= pick_ds;
            last_ds_q <= pick_ds;
            cnt_q     <= '0;
            state_q   <= S_ACCESS;
            if (pick_ds) begin
              rw_q    <= ~bus.ds_we;
              size_q  <= bus.ds_size;
              addr_q  <= bus.ds_addr;
              wdata_q <= bus.ds_wdata;
              bad_q   <= ds_bad;
            end else begin
              rw_q    <= 1'b1;
              size_q  <= 2'b10;
              addr_q  <= bus.if_addr;
              wdata_q <= '0;
              bad_q   <= if_bad;
            end
          end
        end
        S_ACCESS: begin
          if (!mfa_q) begin
            if (bad_q) begin
              res_q     <= '0;
              res_err_q <= 1'b1;
              state_q   <= S_COMPLETE;
            end else begin
              mfa_q <= 1'b1;
            end
          end else if (bus.mem_moc) begin
            mfa_q     <= 1'b0;
            res_q     <= rw_q ? bus.mem_rdata : '0;
            res_err_q <= 1'b0;
            state_q   <= S_COMPLETE;
          end else if (cnt_d == CNT_W'(TIMEOUT)) begin
            mfa_q     <= 1'b0;
            res_q     <= '0;
            res_err_q <= 1'b1;
            state_q   <= S_COMPLETE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_COMPLETE: begin
          if_done_q <= ~gnt_ds_q;
          ds_done_q <= gnt_ds_q;
          rdata_q   <= res_q;
          err_q     <= res_err_q;
          rw_q      <= 1'b0;
          size_q    <= '0;
          addr_q    <= '0;
          wdata_q   <= '0;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.if_done   = if_done_q;
  assign bus.ds_done   = ds_done_q;
  assign bus.rdata     = rdata_q;
  assign bus.err       = err_q;
  assign bus.mem_mfa   = mfa_q;
  assign bus.mem_rw    = rw_q;
  assign bus.mem_size  = size_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
endmodule
